// File: rtl/sj_sumsq_responder.sv
// Synthesijer-style responder for method "calc": returns sum of i*i for i = 1..n, one term per clock.
// Define SJ_CALC_CYCLES_EN to add the calc_cycles output and its LOOP-cycle counter.
module sj_sumsq_responder #(
  parameter int N_W   = 16,
  parameter int RET_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             calc_req,
  input  logic [N_W-1:0]   calc_n,
  output logic             calc_busy,
  output logic [RET_W-1:0] calc_return
`ifdef SJ_CALC_CYCLES_EN
  ,
  output logic [31:0]      calc_cycles
`endif
);

  generate
    if (RET_W < 3 * N_W) begin : g_ret_w_check
      $error("sj_sumsq_responder: RET_W must be >= 3*N_W");
    end
  endgenerate

  typedef enum logic {IDLE, LOOP} state_t;

  state_t           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [N_W:0]     i_q, i_d;
  logic [RET_W-1:0] acc_q, acc_d;
  logic [RET_W-1:0] ret_q, ret_d;
  logic             busy_q, busy_d;
`ifdef SJ_CALC_CYCLES_EN
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      cycles_q, cycles_d;
`endif

  // Square of the loop index, zero-extended to the accumulator width.
  function automatic logic [RET_W-1:0] sq_ext(input logic [N_W:0] v);
    logic [2*N_W+1:0] wide_v;
    logic [2*N_W+1:0] prod;
    wide_v = {{(N_W+1){1'b0}}, v};
    prod   = wide_v * wide_v;
    return RET_W'(prod);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    acc_d   = acc_q;
    ret_d   = ret_q;
    busy_d  = busy_q;
`ifdef SJ_CALC_CYCLES_EN
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
`endif
    case (state_q)
      IDLE: begin
        if (calc_req) begin
          n_d     = calc_n;
          i_d     = {{N_W{1'b0}}, 1'b1};
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = LOOP;
`ifdef SJ_CALC_CYCLES_EN
          cnt_d   = '0;
`endif
        end
      end
      LOOP: begin
`ifdef SJ_CALC_CYCLES_EN
        cnt_d = sat_inc(cnt_q);
`endif
        if (i_q <= {1'b0, n_q}) begin
          acc_d = acc_q + sq_ext(i_q);
          i_d   = i_q + 1'b1;
        end else begin
          // Completion cycle: publish result and count this cycle in calc_cycles.
          ret_d   = acc_q;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef SJ_CALC_CYCLES_EN
          cycles_d = sat_inc(cnt_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      ret_q   <= '0;
      busy_q  <= 1'b0;
`ifdef SJ_CALC_CYCLES_EN
      cnt_q    <= '0;
      cycles_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
      busy_q  <= busy_d;
`ifdef SJ_CALC_CYCLES_EN
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
`endif
    end
  end

  assign calc_busy   = busy_q;
  assign calc_return = ret_q;
`ifdef SJ_CALC_CYCLES_EN
  assign calc_cycles = cycles_q;
`endif

endmodule

// File: tb/tb_sj_sumsq_responder.sv
// Self-checking bench for sj_sumsq_responder: vector table plus scoreboard of expected results.
module tb_sj_sumsq_responder;
  localparam int N_W   = 16;
  localparam int RET_W = 48;

  logic             clk = 1'b0;
  logic             reset;
  logic             calc_req;
  logic [N_W-1:0]   calc_n;
  logic             calc_busy;
  logic [RET_W-1:0] calc_return;
`ifdef SJ_CALC_CYCLES_EN
  logic [31:0]      calc_cycles;
`endif

  sj_sumsq_responder #(.N_W(N_W), .RET_W(RET_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .calc_req    (calc_req),
    .calc_n      (calc_n),
    .calc_busy   (calc_busy),
    .calc_return (calc_return)
`ifdef SJ_CALC_CYCLES_EN
    ,
    .calc_cycles (calc_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    longint unsigned exp_ret;
    bit              poke;
  } vec_t;

  int tests = 0;
  int fails = 0;
  longint unsigned sb_q[$];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one request pulse, waits for completion and compares against the scoreboard.
  // poke: mid-call, change calc_n to 9 and pulse calc_req; both must be ignored.
  task automatic run_call(input string name, input int n_val, input longint unsigned exp_ret, input bit poke);
    int cnt;
    longint unsigned exp;
    @(negedge clk);
    calc_n   = N_W'(n_val);
    calc_req = 1'b1;
    sb_q.push_back(exp_ret);
    @(negedge clk);
    calc_req = 1'b0;
    cnt = 0;
    while (calc_busy === 1'b1 && cnt < 70000) begin
      cnt++;
      if (poke && cnt == 1) begin calc_n = N_W'(9); calc_req = 1'b1; end
      if (poke && cnt == 2) calc_req = 1'b0;
      @(negedge clk);
    end
    if (cnt >= 70000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: busy still high after %0d cycles", name, cnt);
    end
    check({name, "_busy_cycles"}, longint'(cnt), longint'(n_val) + 1);
    exp = sb_q.pop_front();
    check({name, "_return"}, calc_return, exp);
`ifdef SJ_CALC_CYCLES_EN
    check({name, "_cycles"}, calc_cycles, longint'(n_val) + 1);
`endif
    @(negedge clk);
    check({name, "_idle_after"}, calc_busy, 0);
  endtask

  vec_t vecs[4];

  initial begin
    int cnt;
    longint unsigned exp;

    vecs[0] = '{0, 64'd0, 1'b0};
    vecs[1] = '{3, 64'd14, 1'b1};
    vecs[2] = '{100, 64'd338350, 1'b0};
    vecs[3] = '{65535, 64'd93822844764160, 1'b0};

    reset = 1'b1; calc_req = 1'b0; calc_n = '0;
    repeat (5) @(negedge clk);
    check("reset_busy", calc_busy, 0);
    check("reset_return", calc_return, 0);
`ifdef SJ_CALC_CYCLES_EN
    check("reset_cycles", calc_cycles, 0);
`endif
    reset = 1'b0;

    for (int k = 0; k < 4; k++)
      run_call($sformatf("vec%0d_n%0d", k, vecs[k].n), vecs[k].n, vecs[k].exp_ret, vecs[k].poke);

    // Asynchronous abort on the 5th busy cycle of a long call.
    @(negedge clk);
    calc_n = N_W'(1000); calc_req = 1'b1;
    @(negedge clk);
    calc_req = 1'b0;
    cnt = 1;
    while (cnt < 5) begin @(negedge clk); cnt++; end
    check("abort_busy_before", calc_busy, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy_async", calc_busy, 0);
    check("abort_return_async", calc_return, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_after_release", calc_busy, 0);
    run_call("post_abort_n2", 2, 64'd5, 1'b0);

    // Held request: back-to-back calls with one idle cycle between.
    @(negedge clk);
    calc_n = N_W'(10); calc_req = 1'b1;
    sb_q.push_back(64'd385);
    sb_q.push_back(64'd385);
    @(negedge clk);
    cnt = 0;
    while (calc_busy === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
    check("held1_busy_cycles", longint'(cnt), 11);
    exp = sb_q.pop_front();
    check("held1_return", calc_return, exp);
    @(negedge clk);
    check("held_restart_busy", calc_busy, 1);
    calc_req = 1'b0;
    cnt = 1;
    @(negedge clk);
    while (calc_busy === 1'b1 && cnt < 1000) begin cnt++; @(negedge clk); end
    check("held2_busy_cycles", longint'(cnt), 11);
    exp = sb_q.pop_front();
    check("held2_return", calc_return, exp);

    // Pulse during busy is dropped; results 30 then 1.
    run_call("b2b_n4", 4, 64'd30, 1'b1);
    run_call("b2b_n1", 1, 64'd1, 1'b0);

    check("scoreboard_empty", longint'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sj_sumsq_responder.md
Name: sj_sumsq_responder

Overview:
- Hand-written responder for the Synthesijer method-call protocol (req / busy / return), exposing one method "calc".
- A call computes the unsigned sum of i*i for i = 1..n iteratively, one term per clock.
- Drops in wherever a generated module would sit under an initiator bench or a parent module driving calc_req and polling calc_busy.
- Serves as a known-latency reference responder for initiator-side benches.

Parameters:
- N_W, 16, width of argument calc_n.
- RET_W, 48, width of calc_return; must be >= 3*N_W (checked by an elaboration-time assertion).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- calc_req  input  1  method call request; level-sampled in IDLE.
- calc_n  input  N_W  method argument; sampled only on the accepting edge.
- calc_busy  output  1  high while a call is in progress.
- calc_return  output  RET_W  result of the last completed call; valid whenever calc_busy is 0.
- calc_cycles  output  32  present only with SJ_CALC_CYCLES_EN.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, calc_busy=0, calc_return=0, internal i/acc/n_q=0.
  - Asserting reset mid-call aborts immediately; no partial result is written.
- States: IDLE, LOOP. Registered outputs only.
- IDLE:
  - On an edge with calc_req=1: n_q<=calc_n, i<=1, acc<=0, calc_busy<=1, state<=LOOP.
  - Otherwise hold.
- LOOP:
  - If i <= n_q: acc <= acc + i*i, i <= i+1.
  - Else: calc_return <= acc, calc_busy <= 0, state <= IDLE.
- Widths and arithmetic:
  - i is N_W+1 bits so i never wraps at n = 2^N_W-1.
  - i*i is 2*(N_W+1) bits, zero-extended to RET_W. No overflow is possible given the RET_W rule.
- Latency:
  - With req sampled at edge k, calc_busy rises after edge k and falls after edge k+n+1.
  - calc_busy is high for exactly n+1 cycles (n=0 gives 1 cycle).
- calc_return:
  - Updates on the same edge calc_busy falls.
  - Holds its old value throughout a new call; it is not cleared at call start.
- calc_n and calc_req changes while busy are ignored; no queuing.
- Held request: if calc_req stays 1, the block restarts on the edge after completion.
  - calc_busy is low for exactly one cycle between calls, with the new calc_return visible in that cycle.
- Request in the same cycle as reset release: not accepted until the first edge with reset low.

Optional Feature:
- Macro SJ_CALC_CYCLES_EN.
- When defined:
  - Adds a 32-bit cycle counter, cleared on call accept and incremented each LOOP cycle, saturating at 2^32-1.
  - The counter value is copied to calc_cycles on the completion edge, alongside calc_return.
  - calc_cycles resets to 0 and holds between calls.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset cycles 3-8, req pulse with n=0 -> calc_busy high 1 cycle, calc_return=0 (calc_cycles=1 if enabled).
- Req pulse n=3 -> calc_busy high exactly 4 cycles, calc_return=14; changing calc_n to 9 mid-call has no effect.
- Req held high from cycle 101, n=10 -> calc_return=385 when busy first low; busy low 1 cycle, then re-asserted; repeats with 385.
- n=1000, assert reset on 5th busy cycle -> calc_busy=0 and calc_return=0 immediately (asynchronous), IDLE after release; next call n=2 returns 5.
- n=65535 -> calc_busy high 65536 cycles, calc_return=93822844764160, no wrap.
- Back-to-back pulses n=4 then n=1 (second pulse issued during busy, then after) -> second pulse during busy ignored; results 30 then 1.
